ultrasonido_multimodo: RTL and testbench

- Parametrised HC-SR04-class ranging controller; successor to the single-shot fixed-threshold ultrasonic block in the sensor subsystem.
- Generates the trigger pulse and times the echo width in clk cycles.
- Outputs the raw count with a one-cycle valid strobe, plus a near flag against a run-time threshold and a timeout flag.
- Supports single-shot (start pulse) and free-running (auto_en) modes, and enforces a minimum re-trigger period.

---
 rtl/ultra_pkg.sv | 20 ++
 rtl/ultra_echo_sync.sv | 33 +++
 rtl/ultrasonido_multimodo.sv | 139 +++++++++++++
 tb/tb_ultrasonido_multimodo.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ultra_pkg.sv
// Shared state encoding and 50 MHz default timing constants for the ultrasonic ranging controller.
package ultra_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TRIG      = 3'd1,
      WAIT_ECHO = 3'd2,
      MEASURE   = 3'd3,
      HOLDOFF   = 3'd4
   } state_t;

   localparam int DEF_CNT_W          = 22;
   localparam int DEF_TRIG_CYCLES    = 500;      // 10 us
   localparam int DEF_TIMEOUT_CYCLES = 1500000;  // 30 ms
   localparam int DEF_PERIOD_CYCLES  = 3000000;  // 60 ms

   // Echo round trip per centimetre of range; 25 cm corresponds to 73000 cycles.
   localparam int CYCLES_PER_CM      = 2920;

endpackage

// File: rtl/ultra_echo_sync.sv
// Brings the asynchronous echo into the clk domain and flags its rising and falling edges.
module ultra_echo_sync
   import ultra_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic echo,
   output logic echo_s,
   output logic rise,
   output logic fall
);

   logic meta_reg;
   logic sync_reg;
   logic dly_reg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
         dly_reg  <= 1'b0;
      end else begin
         meta_reg <= echo;
         sync_reg <= meta_reg;
         dly_reg  <= sync_reg;
      end
   end

   assign echo_s = sync_reg;
   assign rise   = sync_reg & ~dly_reg;
   assign fall   = ~sync_reg & dly_reg;

endmodule

// File: rtl/ultrasonido_multimodo.sv
// HC-SR04-class ranging controller: trigger generation, echo width timing, near/timeout flags,
// single-shot or free-running operation with a minimum trigger-to-trigger period.
module ultrasonido_multimodo
   import ultra_pkg::*;
#(
   parameter int CNT_W          = DEF_CNT_W,
   parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             auto_en,
   input  logic             echo,
   input  logic [CNT_W-1:0] near_thresh,
   output logic             trigger,
   output logic             busy,
   output logic             meas_valid,
   output logic [CNT_W-1:0] meas_cycles,
   output logic             timeout,
   output logic             near
);

   localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);

   state_t           state_reg;
   logic [CNT_W-1:0] tcnt_reg;
   logic [CNT_W-1:0] wcnt_reg;
   logic [CNT_W-1:0] ecnt_reg;
   logic [CNT_W-1:0] pcnt_reg;
   logic             echo_s;
   logic             rise;
   logic             fall;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   ultra_echo_sync u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .echo    (echo),
      .echo_s  (echo_s),
      .rise    (rise),
      .fall    (fall)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         tcnt_reg    <= '0;
         wcnt_reg    <= '0;
         ecnt_reg    <= '0;
         pcnt_reg    <= '0;
         trigger     <= 1'b0;
         busy        <= 1'b0;
         meas_valid  <= 1'b0;
         meas_cycles <= '0;
         timeout     <= 1'b0;
         near        <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         // pcnt is zero in the first TRIG cycle, so it reads cycles since trigger rise.
         if (state_reg != IDLE)
            pcnt_reg <= sat_inc(pcnt_reg);

         case (state_reg)
            IDLE: begin
               tcnt_reg <= '0;
               wcnt_reg <= '0;
               ecnt_reg <= '0;
               pcnt_reg <= '0;
               if (start | auto_en) begin
                  state_reg <= TRIG;
                  trigger   <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            TRIG: begin
               if (tcnt_reg >= TRIG_LAST) begin
                  trigger   <= 1'b0;
                  state_reg <= WAIT_ECHO;
               end else begin
                  tcnt_reg <= sat_inc(tcnt_reg);
               end
            end
            WAIT_ECHO: begin
               wcnt_reg <= sat_inc(wcnt_reg);
               // An echo already high on entry produces no rise, so it is ignored here.
               if (rise) begin
                  ecnt_reg  <= CNT_W'(1);
                  state_reg <= MEASURE;
               end else if (wcnt_reg >= TIMEOUT_LAST) begin
                  meas_cycles <= TIMEOUT_VAL;
                  timeout     <= 1'b1;
                  near        <= 1'b0;
                  meas_valid  <= 1'b1;
                  state_reg   <= HOLDOFF;
               end
            end
            MEASURE: begin
               // Fall is tested first so a fall coinciding with the limit is a valid result.
               if (fall) begin
                  meas_cycles <= ecnt_reg;
                  timeout     <= 1'b0;
                  near        <= (ecnt_reg < near_thresh);
                  meas_valid  <= 1'b1;
                  state_reg   <= HOLDOFF;
               end else if (ecnt_reg >= TIMEOUT_VAL) begin
                  meas_cycles <= TIMEOUT_VAL;
                  timeout     <= 1'b1;
                  near        <= 1'b0;
                  meas_valid  <= 1'b1;
                  state_reg   <= HOLDOFF;
               end else if (echo_s) begin
                  ecnt_reg <= sat_inc(ecnt_reg);
               end
            end
            HOLDOFF: begin
               if (pcnt_reg >= PERIOD_LAST) begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
               trigger   <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ultrasonido_multimodo.sv
// Directed bench for ultrasonido_multimodo with scaled timing (trigger 5, timeout 100, period 300).
module tb_ultrasonido_multimodo;

   localparam int CW = 12;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          auto_en = 1'b0;
   logic          echo = 1'b0;
   logic [CW-1:0] near_thresh = CW'(40);
   logic          trigger;
   logic          busy;
   logic          meas_valid;
   logic [CW-1:0] meas_cycles;
   logic          timeout;
   logic          near;

   int n_vec = 0;
   int n_err = 0;
   int cur_vec = -1;

   typedef struct {
      int thresh;
      int delay;
      int width;
      int stale;
      int hold_start;
      int exp_cycles;
      int exp_to;
      int exp_near;
      int exp_lat;
   } vec_t;

   vec_t vecs[11];

   always #5 clk = ~clk;

   ultrasonido_multimodo #(
      .CNT_W          (CW),
      .TRIG_CYCLES    (5),
      .TIMEOUT_CYCLES (100),
      .PERIOD_CYCLES  (300)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .auto_en     (auto_en),
      .echo        (echo),
      .near_thresh (near_thresh),
      .trigger     (trigger),
      .busy        (busy),
      .meas_valid  (meas_valid),
      .meas_cycles (meas_cycles),
      .timeout     (timeout),
      .near        (near)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s (vec %0d): got %0d, expected %0d", name, cur_vec, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_trigger"}, int'(trigger), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_meas_valid"}, int'(meas_valid), 0);
      chk({tag, "_meas_cycles"}, int'(meas_cycles), 0);
      chk({tag, "_timeout"}, int'(timeout), 0);
      chk({tag, "_near"}, int'(near), 0);
   endtask

   // One single-shot measurement; echo is driven relative to the observed trigger fall.
   task automatic run_vec(input int idx, input vec_t v);
      int   rise_k = -1, fall_k = -1, valid_k = -1, idle_k = -1;
      int   nvalid = 0, trig_hi = 0, nrise = 0, extra = 0;
      int   got_c = 0, got_to = 0, got_near = 0;
      logic prev_trig = 1'b0, prev_busy = 1'b0;
      cur_vec = idx;
      near_thresh = CW'(v.thresh);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 1000 && idle_k < 0; k++) begin
         if (trigger && !prev_trig) begin
            rise_k = k;
            nrise++;
         end
         if (!trigger && prev_trig) fall_k = k;
         if (trigger) trig_hi++;
         if (meas_valid) begin
            nvalid++;
            if (valid_k < 0) begin
               valid_k  = k;
               got_c    = int'(meas_cycles);
               got_to   = int'(timeout);
               got_near = int'(near);
            end
         end
         if (!busy && prev_busy) idle_k = k;
         if (v.stale != 0)
            echo = (rise_k >= 0 && valid_k < 0);
         else if (v.width > 0 && fall_k >= 0)
            echo = (k >= fall_k + v.delay && k < fall_k + v.delay + v.width);
         else
            echo = 1'b0;
         if (v.hold_start != 0) start = (k == 200);
         prev_trig = trigger;
         prev_busy = busy;
         @(negedge clk);
      end
      echo = 1'b0;
      start = 1'b0;
      chk("busy_release", int'(idle_k >= 0), 1);
      chk("trigger_len", trig_hi, 5);
      chk("trigger_rises", nrise, 1);
      chk("strobe_count", nvalid, 1);
      chk("meas_cycles", got_c, v.exp_cycles);
      chk("timeout", got_to, v.exp_to);
      chk("near", got_near, v.exp_near);
      chk("result_latency", valid_k - fall_k, v.exp_lat);
      chk("period", idle_k - rise_k, 300);
      repeat (5) begin
         if (trigger || busy || meas_valid) extra++;
         @(negedge clk);
      end
      chk("no_requeue", extra, 0);
      chk("retained_cycles", int'(meas_cycles), v.exp_cycles);
      $display("vec %0d: meas_cycles=%0d timeout=%0d near=%0d latency=%0d period=%0d",
               idx, got_c, got_to, got_near, valid_k - fall_k, idle_k - rise_k);
   endtask

   initial begin
      //          thr dly  wid stale hold  cyc  to near lat
      vecs[0]  = '{40, 10,  30, 0, 0,  30, 0, 1,  43};  // near
      vecs[1]  = '{40,  0,   0, 0, 0, 100, 1, 0, 100};  // no echo, clears near
      vecs[2]  = '{40, 10,  60, 0, 0,  60, 0, 0,  73};  // far
      vecs[3]  = '{40, 10, 150, 0, 0, 100, 1, 0, 113};  // stuck echo
      vecs[4]  = '{40, 10,  39, 0, 0,  39, 0, 1,  52};  // just below threshold
      vecs[5]  = '{40,  0,   0, 1, 0, 100, 1, 0, 100};  // stale echo
      vecs[6]  = '{40, 10, 100, 0, 0, 100, 0, 0, 113};  // fall and limit together
      vecs[7]  = '{40, 10, 101, 0, 0, 100, 1, 0, 113};  // one past the limit
      vecs[8]  = '{40, 10,  40, 0, 0,  40, 0, 0,  53};  // equal to threshold
      vecs[9]  = '{ 0, 10,  30, 0, 0,  30, 0, 0,  43};  // zero threshold
      vecs[10] = '{40,  5,  20, 0, 1,  20, 0, 1,  28};  // start during holdoff

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // Free-running mode, then reset while a measurement is in progress.
      begin
         int   rises[$];
         int   last_fall = -1, nval = 0, done = 0, stray = 0;
         logic prev_trig = 1'b0;
         cur_vec = 100;
         near_thresh = CW'(40);
         auto_en = 1'b1;
         @(negedge clk);
         for (int k = 0; k < 1500 && done == 0; k++) begin
            if (trigger && !prev_trig) rises.push_back(k);
            if (!trigger && prev_trig) last_fall = k;
            if (meas_valid) begin
               nval++;
               chk("auto_cycles", int'(meas_cycles), 20);
               chk("auto_timeout", int'(timeout), 0);
               $display("auto result %0d: meas_cycles=%0d timeout=%0d near=%0d",
                        nval, meas_cycles, timeout, near);
            end
            echo = (last_fall >= 0 && k >= last_fall + 10 && k < last_fall + 30);
            if (rises.size() == 3 && last_fall > rises[2] && k == last_fall + 25) done = 1;
            prev_trig = trigger;
            @(negedge clk);
         end
         chk("auto_reached_third", done, 1);
         chk("auto_results", nval, 2);
         if (done != 0) begin
            chk("auto_period_1", rises[1] - rises[0], 301);
            chk("auto_period_2", rises[2] - rises[1], 301);
         end
         reset_n = 1'b0;
         @(negedge clk);
         chk_all_zero("midreset");
         auto_en = 1'b0;
         echo = 1'b0;
         @(negedge clk);
         reset_n = 1'b1;
         repeat (10) begin
            if (meas_valid || trigger || busy) stray++;
            @(negedge clk);
         end
         chk("post_reset_quiet", stray, 0);
         $display("auto mode: trigger period %0d/%0d, reset abort done", 
                  (done != 0) ? rises[1] - rises[0] : -1,
                  (done != 0) ? rises[2] - rises[1] : -1);
      end

      run_vec(200, vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
